fu_result_buffer: RTL and testbench

- Sits between the functional units and the complete stage.
- Holds one finished result per FU in an 8-entry slot array and drives the complete stage's `fu_finish` and `fu_c_in[2:0]` using the same priority selection the complete stage applies.
- Retains each result until the complete stage stops stalling that FU, and back-pressures the FU while its slot is held.
- Squash clears every slot on a precise-state recovery.

---
 rtl/fu_result_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_fu_result_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_result_buffer.sv
// fu_result_buffer: one result slot per functional unit, 3-lane priority selection toward the complete stage.
// Optional same-cycle bypass into empty slots is enabled by defining FU_RESULT_BYPASS_EN.

package fu_result_buffer_pkg;
    localparam int PR_W  = 6;
    localparam int ROB_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  dest_value;
        logic [ROB_W-1:0] rob_entry;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
    } fu_complete_packet_t;

    typedef logic [7:0] fu_state_packet_t;
endpackage

module fu_result_buffer_chk #(
    parameter int NUM_FU = 8
) (
    input logic              clock,
    input logic              reset,
    input logic              squash,
    input logic [NUM_FU-1:0] fu_done,
    input logic [NUM_FU-1:0] fu_c_stall,
    input logic [NUM_FU-1:0] valid,
    input logic [NUM_FU-1:0] fu_ready
);
    // A held slot must never be offered a new result unless squash discards it.
    property p_no_done_while_held;
        @(posedge clock) disable iff (!reset)
        !squash |-> ((fu_done & valid & fu_c_stall) == {NUM_FU{1'b0}});
    endproperty

    a_no_done_while_held: assert property (p_no_done_while_held)
        else $error("fu_result_buffer: fu_done asserted on a held slot");

    // An empty slot always accepts a result.
    a_empty_ready: assert property (@(posedge clock) disable iff (!reset)
        ((~valid & ~fu_ready) == {NUM_FU{1'b0}}))
        else $error("fu_result_buffer: empty slot not ready");
endmodule

module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int NUM_FU = 8,
    parameter int NUM_WB = 3,
    parameter int CNT_W  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [NUM_FU-1:0]                   fu_done,
    input  fu_complete_packet_t [NUM_FU-1:0]    fu_result,
    input  fu_state_packet_t                    fu_c_stall,
    output logic [NUM_FU-1:0]                   fu_ready,
    output fu_state_packet_t                    fu_finish,
    output fu_complete_packet_t [NUM_WB-1:0]    fu_c_in,
    output logic [CNT_W-1:0]                    stall_count
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t                     state_r     [NUM_FU];
    slot_state_t                     state_nxt_s [NUM_FU];
    fu_complete_packet_t [NUM_FU-1:0] payload_r;
    fu_complete_packet_t [NUM_FU-1:0] view_s;
    logic [NUM_FU-1:0]               load_s;
    logic [NUM_FU-1:0]               valid_s;
    logic [NUM_FU-1:0]               fin_s;
    logic [1:0]                      sel_cnt_s;
    logic [CNT_W-1:0]                stall_count_r;

    // Slot state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_r[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Per-slot next state and payload load enable; squash wins over drain and refill.
    always_comb begin
        load_s = {NUM_FU{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            state_nxt_s[i] = state_r[i];
            if (squash) begin
                state_nxt_s[i] = EMPTY;
            end else begin
                case (state_r[i])
                    EMPTY: begin
`ifdef FU_RESULT_BYPASS_EN
                        // Unstalled results went straight through the bypass; only stalled ones are kept.
                        if (fu_done[i] && fu_c_stall[i]) begin
                            state_nxt_s[i] = FULL;
                            load_s[i]      = 1'b1;
                        end else begin
                            state_nxt_s[i] = EMPTY;
                        end
`else
                        if (fu_done[i]) begin
                            state_nxt_s[i] = FULL;
                            load_s[i]      = 1'b1;
                        end else begin
                            state_nxt_s[i] = EMPTY;
                        end
`endif
                    end
                    FULL: begin
                        if (fu_c_stall[i]) begin
                            state_nxt_s[i] = FULL;
                        end else if (fu_done[i]) begin
                            state_nxt_s[i] = FULL;
                            load_s[i]      = 1'b1;
                        end else begin
                            state_nxt_s[i] = EMPTY;
                        end
                    end
                    default: begin
                        state_nxt_s[i] = EMPTY;
                    end
                endcase
            end
        end
    end

    // Slot payload storage; zeroed on squash so stale data never lingers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            payload_r <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (squash) begin
                    payload_r[i] <= '0;
                end else if (load_s[i]) begin
                    payload_r[i] <= fu_result[i];
                end else begin
                    payload_r[i] <= payload_r[i];
                end
            end
        end
    end

    // Visible slot status and the payload each slot presents to the selector.
    always_comb begin
        valid_s = {NUM_FU{1'b0}};
        fin_s   = {NUM_FU{1'b0}};
        view_s  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            valid_s[i] = (state_r[i] == FULL);
`ifdef FU_RESULT_BYPASS_EN
            fin_s[i]  = valid_s[i] | (fu_done[i] & ~valid_s[i] & ~squash);
            view_s[i] = valid_s[i] ? payload_r[i] : fu_result[i];
`else
            fin_s[i]  = valid_s[i];
            view_s[i] = payload_r[i];
`endif
        end
    end

    // Highest-index finished slots fill lanes 2, 1, 0 in that order; unused lanes stay zero.
    always_comb begin
        sel_cnt_s = 2'd0;
        fu_c_in   = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (fin_s[i] && (sel_cnt_s != 2'd3)) begin
                case (sel_cnt_s)
                    2'd0:    fu_c_in[2] = view_s[i];
                    2'd1:    fu_c_in[1] = view_s[i];
                    2'd2:    fu_c_in[0] = view_s[i];
                    default: fu_c_in[0] = fu_c_in[0];
                endcase
                sel_cnt_s = sel_cnt_s + 2'd1;
            end else begin
                sel_cnt_s = sel_cnt_s;
            end
        end
    end

    // Count cycles in which the complete stage stalled any slot; squash leaves it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (|fu_c_stall) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign fu_ready    = ~valid_s | ~fu_c_stall;
    assign fu_finish   = fin_s;
    assign stall_count = stall_count_r;

    fu_result_buffer_chk #(.NUM_FU(NUM_FU)) u_chk (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_done    (fu_done),
        .fu_c_stall (fu_c_stall),
        .valid      (valid_s),
        .fu_ready   (fu_ready)
    );
endmodule

// File: tb/tb_fu_result_buffer.sv
// Self-checking bench for fu_result_buffer: directed scenarios plus random traffic against a slot-level model.
`timescale 1ns/1ps
module tb_fu_result_buffer;
    import fu_result_buffer_pkg::*;

    typedef fu_complete_packet_t [2:0] lanes_t;

`ifdef FU_RESULT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                           clock = 1'b0;
    logic                           reset;
    logic                           squash;
    logic [7:0]                     fu_done;
    fu_complete_packet_t [7:0]      fu_result;
    logic [7:0]                     fu_c_stall;
    logic [7:0]                     fu_ready;
    logic [7:0]                     fu_finish;
    lanes_t                         fu_c_in;
    logic [31:0]                    stall_count;

    int tests = 0;
    int fails = 0;

    // Reference model: per-slot occupancy, stored result and the stall counter.
    bit                  m_valid [8];
    fu_complete_packet_t m_pay   [8];
    logic [31:0]         m_cnt;

    fu_result_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_done     (fu_done),
        .fu_result   (fu_result),
        .fu_c_stall  (fu_c_stall),
        .fu_ready    (fu_ready),
        .fu_finish   (fu_finish),
        .fu_c_in     (fu_c_in),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic fu_complete_packet_t rand_pkt();
        fu_complete_packet_t p;
        p.dest_pr        = 6'($urandom);
        p.dest_value     = $urandom;
        p.rob_entry      = 5'($urandom);
        p.if_take_branch = 1'($urandom);
        p.target_pc      = $urandom;
        return p;
    endfunction

    function automatic logic [7:0] exp_finish();
        logic [7:0] f;
        for (int i = 0; i < 8; i++)
            f[i] = m_valid[i] || (BYPASS && fu_done[i] && !squash);
        return f;
    endfunction

    function automatic logic [7:0] exp_ready();
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = !(m_valid[i] && fu_c_stall[i]);
        return r;
    endfunction

    function automatic lanes_t exp_c_in();
        lanes_t     l;
        int         q[$];
        logic [7:0] f;
        f = exp_finish();
        l = '0;
        for (int i = 7; i >= 0; i--)
            if (f[i]) q.push_back(i);
        for (int k = 0; k < 3 && k < q.size(); k++)
            l[2-k] = m_valid[q[k]] ? m_pay[q[k]] : fu_result[q[k]];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_pay[i]   = '0;
        end
        m_cnt = 32'd0;
    endtask

    // Apply the slot rules for the current inputs, then advance one clock.
    task automatic tick();
        bit                  nv [8];
        fu_complete_packet_t np [8];
        logic [31:0]         nc;
        for (int i = 0; i < 8; i++) begin
            nv[i] = m_valid[i];
            np[i] = m_pay[i];
            if (squash) begin
                nv[i] = 1'b0;
                np[i] = '0;
            end else if (m_valid[i] && !fu_c_stall[i]) begin
                nv[i] = fu_done[i];
                if (fu_done[i]) np[i] = fu_result[i];
            end else if (!m_valid[i] && fu_done[i] && (!BYPASS || fu_c_stall[i])) begin
                nv[i] = 1'b1;
                np[i] = fu_result[i];
            end
        end
        nc = (|fu_c_stall) ? m_cnt + 32'd1 : m_cnt;
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = nv[i];
            m_pay[i]   = np[i];
        end
        m_cnt = nc;
    endtask

    task automatic drive_idle();
        squash     = 1'b0;
        fu_done    = 8'h00;
        fu_c_stall = 8'h00;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        fu_result = '0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL reset_finish: got %h expected 00", fu_finish); end
        tests++; if (fu_c_in !== '0) begin fails++; $display("FAIL reset_c_in: got %h expected 0", fu_c_in); end
        tests++; if (fu_ready !== 8'hFF) begin fails++; $display("FAIL reset_ready: got %h expected ff", fu_ready); end
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] ef;
        fu_result[0]            = '0;
        fu_result[0].dest_pr    = 6'd5;
        fu_result[0].dest_value = 32'hDEAD;
        fu_done = 8'h01;
        #1;
        ef = BYPASS ? 8'h01 : 8'h00;
        tests++; if (fu_finish !== ef) begin fails++; $display("FAIL single_same_cycle: got %h expected %h", fu_finish, ef); end
        tick();
        fu_done = 8'h00;
        #1;
        ef = BYPASS ? 8'h00 : 8'h01;
        tests++; if (fu_finish !== ef) begin fails++; $display("FAIL single_finish: got %h expected %h", fu_finish, ef); end
        tests++; if (fu_c_in[2].dest_pr !== (BYPASS ? 6'd0 : 6'd5)) begin fails++; $display("FAIL single_dest_pr: got %0d", fu_c_in[2].dest_pr); end
        tests++; if (fu_c_in[1] !== '0 || fu_c_in[0] !== '0) begin fails++; $display("FAIL single_unused_lanes: got %h %h expected 0", fu_c_in[1], fu_c_in[0]); end
        tests++; if (fu_c_in !== exp_c_in()) begin fails++; $display("FAIL single_c_in: got %h expected %h", fu_c_in, exp_c_in()); end
        tick();
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL single_drain: got %h expected 00", fu_finish); end
    endtask

    task automatic test_priority();
        fu_complete_packet_t p [8];
        for (int i = 0; i < 8; i++) begin
            p[i] = rand_pkt();
            fu_result[i] = p[i];
        end
        fu_done    = 8'b1100_1011;
        fu_c_stall = 8'b1100_1011;
        tick();
        fu_done    = 8'h00;
        fu_c_stall = 8'b0000_0011;
        #1;
        tests++; if (fu_finish !== 8'b1100_1011) begin fails++; $display("FAIL prio_finish: got %h expected cb", fu_finish); end
        tests++; if (fu_c_in[2] !== p[7] || fu_c_in[1] !== p[6] || fu_c_in[0] !== p[3]) begin fails++; $display("FAIL prio_lanes: got %h", fu_c_in); end
        tick();
        tests++; if (stall_count !== m_cnt) begin fails++; $display("FAIL prio_count: got %0d expected %0d", stall_count, m_cnt); end
        fu_c_stall = 8'h00;
        #1;
        tests++; if (fu_finish !== 8'h03) begin fails++; $display("FAIL prio_wait_finish: got %h expected 03", fu_finish); end
        tests++; if (fu_c_in[2] !== p[1] || fu_c_in[1] !== p[0] || fu_c_in[0] !== '0) begin fails++; $display("FAIL prio_wait_lanes: got %h", fu_c_in); end
        tick();
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL prio_drain: got %h expected 00", fu_finish); end
    endtask

    task automatic test_back_to_back();
        fu_complete_packet_t a, b;
        a = rand_pkt();
        fu_result[2] = a;
        fu_done      = 8'h04;
        fu_c_stall   = 8'h04;
        tick();
        fu_done = 8'h00;
        #1;
        tests++; if (fu_ready[2] !== 1'b0) begin fails++; $display("FAIL hold_ready: got %b expected 0", fu_ready[2]); end
        for (int c = 0; c < 4; c++) begin
            fu_result[2] = rand_pkt();
            tick();
            tests++; if (fu_c_in[2] !== a || fu_finish !== 8'h04) begin fails++; $display("FAIL hold_payload: cycle %0d got %h expected %h", c, fu_c_in[2], a); end
        end
        b = rand_pkt();
        fu_result[2] = b;
        fu_c_stall   = 8'h00;
        fu_done      = 8'h04;
        #1;
        tests++; if (fu_ready[2] !== 1'b1) begin fails++; $display("FAIL release_ready: got %b expected 1", fu_ready[2]); end
        tick();
        fu_done = 8'h00;
        #1;
        tests++; if (fu_finish !== 8'h04 || fu_c_in[2] !== b) begin fails++; $display("FAIL refill: got %h %h expected 04 %h", fu_finish, fu_c_in[2], b); end
        tick();
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL refill_drain: got %h expected 00", fu_finish); end
    endtask

    task automatic test_full_drain();
        logic [7:0] stalls [3];
        logic [7:0] finish [3];
        stalls = '{8'h1F, 8'h03, 8'h00};
        finish = '{8'hFF, 8'h1F, 8'h03};
        for (int i = 0; i < 8; i++) fu_result[i] = rand_pkt();
        fu_done    = 8'hFF;
        fu_c_stall = 8'hFF;
        tick();
        fu_done = 8'h00;
        for (int c = 0; c < 3; c++) begin
            fu_c_stall = stalls[c];
            #1;
            tests++; if (fu_finish !== finish[c]) begin fails++; $display("FAIL full_drain: cycle %0d got %h expected %h", c, fu_finish, finish[c]); end
            tests++; if (fu_c_in !== exp_c_in()) begin fails++; $display("FAIL full_drain_c_in: cycle %0d got %h expected %h", c, fu_c_in, exp_c_in()); end
            tick();
        end
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL full_drain_end: got %h expected 00", fu_finish); end
    endtask

    task automatic test_squash();
        for (int i = 0; i < 8; i++) fu_result[i] = rand_pkt();
        fu_done    = 8'hFF;
        fu_c_stall = 8'hFF;
        tick();
        for (int i = 0; i < 8; i++) fu_result[i] = rand_pkt();
        squash     = 1'b1;
        fu_done    = 8'hFF;
        fu_c_stall = 8'h1F;
        #1;
        tests++; if (fu_finish !== 8'hFF) begin fails++; $display("FAIL squash_before: got %h expected ff", fu_finish); end
        tick();
        drive_idle();
        #1;
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL squash_finish: got %h expected 00", fu_finish); end
        tests++; if (fu_c_in !== '0) begin fails++; $display("FAIL squash_c_in: got %h expected 0", fu_c_in); end
        tests++; if (fu_ready !== 8'hFF) begin fails++; $display("FAIL squash_ready: got %h expected ff", fu_ready); end
        tests++; if (stall_count !== m_cnt) begin fails++; $display("FAIL squash_count: got %0d expected %0d", stall_count, m_cnt); end
    endtask

    task automatic test_async_reset();
        fu_complete_packet_t p;
        for (int i = 0; i < 8; i++) fu_result[i] = rand_pkt();
        fu_done    = 8'b1011_0101;
        fu_c_stall = 8'b1011_0101;
        tick();
        fu_done    = 8'h00;
        fu_c_stall = 8'hFF;
        #1;
        tests++; if (fu_finish !== 8'hB5) begin fails++; $display("FAIL areset_before: got %h expected b5", fu_finish); end
        #1;
        reset = 1'b0;
        #1;
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL areset_finish: got %h expected 00", fu_finish); end
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL areset_count: got %0d expected 0", stall_count); end
        tests++; if (fu_c_in !== '0) begin fails++; $display("FAIL areset_c_in: got %h expected 0", fu_c_in); end
        model_reset();
        drive_idle();
        @(posedge clock);
        #1;
        reset = 1'b1;
        p = rand_pkt();
        fu_result[1] = p;
        fu_done      = 8'h02;
        fu_c_stall   = 8'h02;
        tick();
        drive_idle();
        #1;
        tests++; if (fu_finish !== 8'h02 || fu_c_in[2] !== p) begin fails++; $display("FAIL areset_resume: got %h %h expected 02 %h", fu_finish, fu_c_in[2], p); end
        tests++; if (stall_count !== 32'd1) begin fails++; $display("FAIL areset_resume_count: got %0d expected 1", stall_count); end
        tick();
    endtask

`ifdef FU_RESULT_BYPASS_EN
    task automatic test_bypass();
        fu_complete_packet_t p;
        drive_idle();
        squash = 1'b1;
        tick();
        squash = 1'b0;
        p = rand_pkt();
        fu_result[4] = p;
        fu_done      = 8'h10;
        #1;
        tests++; if (fu_finish !== 8'h10) begin fails++; $display("FAIL bypass_finish: got %h expected 10", fu_finish); end
        tests++; if (fu_c_in[2] !== p) begin fails++; $display("FAIL bypass_lane: got %h expected %h", fu_c_in[2], p); end
        tick();
        fu_done = 8'h00;
        #1;
        tests++; if (fu_finish !== 8'h00) begin fails++; $display("FAIL bypass_no_capture: got %h expected 00", fu_finish); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] occ;
        int         n;
        for (int c = 0; c < 400; c++) begin
            squash = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) begin
                fu_c_stall = 8'($urandom);
            end else begin
                // Behave like the complete stage: stall every held slot beyond the top three.
                occ = 8'h00;
                for (int i = 0; i < 8; i++) occ[i] = m_valid[i];
                fu_c_stall = 8'h00;
                n = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (occ[i]) begin
                        if (n >= 3) fu_c_stall[i] = 1'b1;
                        n++;
                    end
                end
            end
            for (int i = 0; i < 8; i++) fu_result[i] = rand_pkt();
            fu_done = 8'($urandom) & exp_ready();
            #1;
            tests++; if (fu_finish !== exp_finish()) begin fails++; $display("FAIL rand_finish: cycle %0d got %h expected %h", c, fu_finish, exp_finish()); end
            tests++; if (fu_c_in !== exp_c_in()) begin fails++; $display("FAIL rand_c_in: cycle %0d got %h expected %h", c, fu_c_in, exp_c_in()); end
            tests++; if (fu_ready !== exp_ready()) begin fails++; $display("FAIL rand_ready: cycle %0d got %h expected %h", c, fu_ready, exp_ready()); end
            tests++; if (stall_count !== m_cnt) begin fails++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", c, stall_count, m_cnt); end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        @(posedge clock);
        #1;
        test_single();
        test_priority();
        test_back_to_back();
        test_full_drain();
        test_squash();
        test_async_reset();
`ifdef FU_RESULT_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
